ysyx_22050019_axi_arbiter: RTL and testbench

Two-master, one-slave AXI-lite arbiter that shares the single memory port between the IFU (read-only) and the LSU (read and write). It sits between the core's fetch/load-store units and the memory/crossbar slave. It grants one transaction at a time: single beat, single outstanding, across both read and write. Read grants alternate round-robin between IFU and LSU so neither starves.

---
 rtl/ysyx_22050019_axi_pkg.sv | 13 +
 rtl/ysyx_22050019_rr_arb2.sv | 13 +
 rtl/ysyx_22050019_axi_arbiter.sv | 123 ++++++++++++
 tb/tb_ysyx_22050019_axi_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050019_axi_pkg.sv
// ysyx_22050019_axi_pkg: shared state encoding, read-grant ids and AXI resp codes for the arbiter
package ysyx_22050019_axi_pkg;
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_IFU_R  = 3'd1;
   localparam logic [2:0] S_LSU_R  = 3'd2;
   localparam logic [2:0] S_LSU_AW = 3'd3;
   localparam logic [2:0] S_LSU_W  = 3'd4;
   localparam logic [2:0] S_LSU_B  = 3'd5;
   localparam logic GNT_IFU = 1'b0;
   localparam logic GNT_LSU = 1'b1;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
endpackage

// File: rtl/ysyx_22050019_rr_arb2.sv
// ysyx_22050019_rr_arb2: two-way round-robin picker, req[0]=IFU req[1]=LSU, one-hot gnt
module ysyx_22050019_rr_arb2
   import ysyx_22050019_axi_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);
   always_comb begin
      gnt[0] = req[0] & (~req[1] | (last == GNT_LSU));
      gnt[1] = req[1] & (~req[0] | (last == GNT_IFU));
   end
endmodule

// File: rtl/ysyx_22050019_axi_arbiter.sv
// ysyx_22050019_axi_arbiter: shares one AXI-lite slave between IFU (read) and LSU (read/write),
// one single-beat transaction at a time, writes first, reads round-robin.
module ysyx_22050019_axi_arbiter
   import ysyx_22050019_axi_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_ar_valid,
   output logic                ifu_ar_ready,
   input  logic [ADDR_W-1:0]   ifu_ar_addr,
   output logic                ifu_r_valid,
   input  logic                ifu_r_ready,
   output logic [DATA_W-1:0]   ifu_r_data,
   output logic [1:0]          ifu_r_resp,
   input  logic                lsu_ar_valid,
   output logic                lsu_ar_ready,
   input  logic [ADDR_W-1:0]   lsu_ar_addr,
   output logic                lsu_r_valid,
   input  logic                lsu_r_ready,
   output logic [DATA_W-1:0]   lsu_r_data,
   output logic [1:0]          lsu_r_resp,
   input  logic                lsu_aw_valid,
   output logic                lsu_aw_ready,
   input  logic [ADDR_W-1:0]   lsu_aw_addr,
   input  logic                lsu_w_valid,
   output logic                lsu_w_ready,
   input  logic [DATA_W-1:0]   lsu_w_data,
   input  logic [DATA_W/8-1:0] lsu_w_strb,
   output logic                lsu_b_valid,
   input  logic                lsu_b_ready,
   output logic [1:0]          lsu_b_resp,
   output logic                m_ar_valid,
   input  logic                m_ar_ready,
   output logic [ADDR_W-1:0]   m_ar_addr,
   input  logic                m_r_valid,
   output logic                m_r_ready,
   input  logic [DATA_W-1:0]   m_r_data,
   input  logic [1:0]          m_r_resp,
   output logic                m_aw_valid,
   input  logic                m_aw_ready,
   output logic [ADDR_W-1:0]   m_aw_addr,
   output logic                m_w_valid,
   input  logic                m_w_ready,
   output logic [DATA_W-1:0]   m_w_data,
   output logic [DATA_W/8-1:0] m_w_strb,
   input  logic                m_b_valid,
   output logic                m_b_ready,
   input  logic [1:0]          m_b_resp
);
   logic [2:0] state, state_nxt;
   logic       last_rd_grant, last_nxt;
   logic [1:0] gnt;
   logic       aw_ph, ar_ph, ifu_own, lsu_own, w_ph, b_ph;

   ysyx_22050019_rr_arb2 u_rr (
      .req  ({lsu_ar_valid, ifu_ar_valid}),
      .last (last_rd_grant),
      .gnt  (gnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         last_rd_grant <= GNT_LSU;
      end else begin
         state         <= state_nxt;
         last_rd_grant <= last_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last_rd_grant;
      case (state)
         S_IDLE:
            if (lsu_aw_valid) state_nxt = m_aw_ready ? S_LSU_W : S_LSU_AW;
            else if (m_ar_valid & m_ar_ready) begin
               state_nxt = gnt[1] ? S_LSU_R : S_IFU_R;
               last_nxt  = gnt[1] ? GNT_LSU : GNT_IFU;
            end
         S_LSU_AW: state_nxt = (m_aw_valid & m_aw_ready) ? S_LSU_W : S_LSU_AW;
         S_IFU_R:  state_nxt = (m_r_valid & m_r_ready) ? S_IDLE : S_IFU_R;
         S_LSU_R:  state_nxt = (m_r_valid & m_r_ready) ? S_IDLE : S_LSU_R;
         S_LSU_W:  state_nxt = (m_w_valid & m_w_ready) ? S_LSU_B : S_LSU_W;
         S_LSU_B:  state_nxt = (m_b_valid & m_b_ready) ? S_IDLE : S_LSU_B;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // every phase is masked by rst so no handshake leaks out while in reset
   always_comb begin
      aw_ph        = ~rst & (((state == S_IDLE) & lsu_aw_valid) | (state == S_LSU_AW));
      ar_ph        = ~rst & (state == S_IDLE) & ~lsu_aw_valid;
      ifu_own      = ~rst & (state == S_IFU_R);
      lsu_own      = ~rst & (state == S_LSU_R);
      w_ph         = ~rst & (state == S_LSU_W);
      b_ph         = ~rst & (state == S_LSU_B);
      m_aw_valid   = aw_ph & lsu_aw_valid;
      m_aw_addr    = aw_ph ? lsu_aw_addr : '0;
      lsu_aw_ready = aw_ph & m_aw_ready;
      m_ar_valid   = ar_ph & (|gnt);
      m_ar_addr    = (ar_ph & gnt[1]) ? lsu_ar_addr : (ar_ph & gnt[0]) ? ifu_ar_addr : '0;
      ifu_ar_ready = ar_ph & gnt[0] & m_ar_ready;
      lsu_ar_ready = ar_ph & gnt[1] & m_ar_ready;
      m_r_ready    = ifu_own ? ifu_r_ready : lsu_own ? lsu_r_ready : 1'b0;
      ifu_r_valid  = ifu_own & m_r_valid;
      ifu_r_data   = ifu_own ? m_r_data : '0;
      ifu_r_resp   = ifu_own ? m_r_resp : OKAY;
      lsu_r_valid  = lsu_own & m_r_valid;
      lsu_r_data   = lsu_own ? m_r_data : '0;
      lsu_r_resp   = lsu_own ? m_r_resp : OKAY;
      m_w_valid    = w_ph & lsu_w_valid;
      m_w_data     = w_ph ? lsu_w_data : '0;
      m_w_strb     = w_ph ? lsu_w_strb : '0;
      lsu_w_ready  = w_ph & m_w_ready;
      m_b_ready    = b_ph & lsu_b_ready;
      lsu_b_valid  = b_ph & m_b_valid;
      lsu_b_resp   = b_ph ? m_b_resp : OKAY;
   end
endmodule

// File: tb/tb_ysyx_22050019_axi_arbiter.sv
// tb_ysyx_22050019_axi_arbiter: directed bench with a grant/data scoreboard for the AXI-lite arbiter
module tb_ysyx_22050019_axi_arbiter;
   import ysyx_22050019_axi_pkg::*;
   logic clk = 1'b0;
   logic rst;
   logic ifu_ar_valid, ifu_ar_ready, ifu_r_valid, ifu_r_ready;
   logic [63:0] ifu_ar_addr, ifu_r_data;
   logic [1:0] ifu_r_resp;
   logic lsu_ar_valid, lsu_ar_ready, lsu_r_valid, lsu_r_ready;
   logic [63:0] lsu_ar_addr, lsu_r_data;
   logic [1:0] lsu_r_resp;
   logic lsu_aw_valid, lsu_aw_ready, lsu_w_valid, lsu_w_ready, lsu_b_valid, lsu_b_ready;
   logic [63:0] lsu_aw_addr, lsu_w_data;
   logic [7:0] lsu_w_strb;
   logic [1:0] lsu_b_resp;
   logic m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
   logic [63:0] m_ar_addr, m_r_data;
   logic [1:0] m_r_resp;
   logic m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
   logic [63:0] m_aw_addr, m_w_data;
   logic [7:0] m_w_strb;
   logic [1:0] m_b_resp;

   typedef struct {
      logic [1:0]  gnt;
      logic [63:0] data;
   } exp_t;
   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_22050019_axi_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .rst(rst),
      .ifu_ar_valid(ifu_ar_valid), .ifu_ar_ready(ifu_ar_ready), .ifu_ar_addr(ifu_ar_addr),
      .ifu_r_valid(ifu_r_valid), .ifu_r_ready(ifu_r_ready), .ifu_r_data(ifu_r_data), .ifu_r_resp(ifu_r_resp),
      .lsu_ar_valid(lsu_ar_valid), .lsu_ar_ready(lsu_ar_ready), .lsu_ar_addr(lsu_ar_addr),
      .lsu_r_valid(lsu_r_valid), .lsu_r_ready(lsu_r_ready), .lsu_r_data(lsu_r_data), .lsu_r_resp(lsu_r_resp),
      .lsu_aw_valid(lsu_aw_valid), .lsu_aw_ready(lsu_aw_ready), .lsu_aw_addr(lsu_aw_addr),
      .lsu_w_valid(lsu_w_valid), .lsu_w_ready(lsu_w_ready), .lsu_w_data(lsu_w_data), .lsu_w_strb(lsu_w_strb),
      .lsu_b_valid(lsu_b_valid), .lsu_b_ready(lsu_b_ready), .lsu_b_resp(lsu_b_resp),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
      .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
      .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
      .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
      .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] all_hs();
      return {ifu_ar_ready, ifu_r_valid, lsu_ar_ready, lsu_r_valid, lsu_aw_ready, lsu_w_ready,
              lsu_b_valid, m_ar_valid, m_r_ready, m_aw_valid, m_w_valid, m_b_ready, 4'h0};
   endfunction

   // AR cycle then R cycle; the popped entry gives the expected winner and the read data
   task automatic rd_txn();
      exp_t e;
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      e = sb.pop_front();
      @(negedge clk);
      m_ar_ready = 1'b1;
      #1;
      chk("m_ar_valid", 64'(m_ar_valid), 64'd1);
      chk("ar_gnt", 64'({lsu_ar_ready, ifu_ar_ready}), 64'(e.gnt));
      @(posedge clk);
      @(negedge clk);
      m_ar_ready = 1'b0;
      m_r_valid = 1'b1;
      m_r_data = e.data;
      m_r_resp = SLVERR;
      ifu_r_ready = 1'b1;
      lsu_r_ready = 1'b1;
      #1;
      chk("r_valid_route", 64'({ifu_r_valid, lsu_r_valid}), (e.gnt == 2'b01) ? 64'h2 : 64'h1);
      chk("r_data", (e.gnt == 2'b01) ? ifu_r_data : lsu_r_data, e.data);
      chk("r_resp", 64'((e.gnt == 2'b01) ? ifu_r_resp : lsu_r_resp), 64'(SLVERR));
      @(posedge clk);
      @(negedge clk);
      m_r_valid = 1'b0;
      ifu_r_ready = 1'b0;
      lsu_r_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      {ifu_ar_valid, ifu_r_ready, lsu_ar_valid, lsu_r_ready, lsu_aw_valid, lsu_w_valid, lsu_b_ready} = '0;
      {m_ar_ready, m_r_valid, m_aw_ready, m_w_ready, m_b_valid} = '0;
      ifu_ar_addr = '0; lsu_ar_addr = '0; lsu_aw_addr = '0; lsu_w_data = '0; lsu_w_strb = '0;
      m_r_data = '0; m_r_resp = OKAY; m_b_resp = OKAY;
      @(negedge clk);
      ifu_ar_valid = 1'b1;
      m_ar_ready = 1'b1;
      #1;
      chk("reset_outputs", 64'(all_hs()), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ifu_ar_valid = 1'b0;
      m_ar_ready = 1'b0;
      #1;
      chk("reset_state", 64'(dut.state), 64'(S_IDLE));
      // single IFU fetch, address forwarded in the same cycle
      ifu_ar_valid = 1'b1;
      ifu_ar_addr = 64'h8000_0000;
      #1;
      chk("ifu_ar_addr", m_ar_addr, 64'h8000_0000);
      sb.push_back('{2'b01, 64'h1234});
      rd_txn();
      ifu_ar_valid = 1'b0;
      // slave stalls AR for 3 cycles; LSU request must wait in IDLE
      lsu_ar_valid = 1'b1;
      lsu_ar_addr = 64'h2000;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_state", 64'(dut.state), 64'(S_IDLE));
         chk("stall_addr", {m_ar_addr[62:0], m_ar_valid}, {63'h2000, 1'b1});
         @(negedge clk);
      end
      sb.push_back('{2'b10, 64'h5555});
      rd_txn();
      lsu_ar_valid = 1'b0;
      // tie for four reads: round-robin starts with IFU since LSU went last
      ifu_ar_valid = 1'b1;
      lsu_ar_valid = 1'b1;
      ifu_ar_addr = 64'h100;
      lsu_ar_addr = 64'h200;
      sb.push_back('{2'b01, 64'hA1});
      sb.push_back('{2'b10, 64'hB2});
      sb.push_back('{2'b01, 64'hC3});
      sb.push_back('{2'b10, 64'hD4});
      for (int i = 0; i < 4; i++) rd_txn();
      lsu_ar_valid = 1'b0;
      // write beats a simultaneous IFU read; AW stalls one cycle
      @(negedge clk);
      lsu_aw_valid = 1'b1;
      lsu_aw_addr = 64'h300;
      m_ar_ready = 1'b1;
      #1;
      chk("aw_priority", 64'({m_aw_valid, m_ar_valid, ifu_ar_ready}), 64'b100);
      @(posedge clk);
      @(negedge clk);
      m_ar_ready = 1'b0;
      m_aw_ready = 1'b1;
      #1;
      chk("aw_hold", {m_aw_addr[61:0], lsu_aw_ready, m_ar_valid}, {62'h300, 2'b10});
      @(posedge clk);
      @(negedge clk);
      lsu_aw_valid = 1'b0;
      m_aw_ready = 1'b0;
      lsu_w_valid = 1'b1;
      lsu_w_data = 64'hdead_beef;
      lsu_w_strb = 8'h0f;
      m_w_ready = 1'b1;
      #1;
      chk("w_fwd", {m_w_data[55:0], m_w_strb}, {56'hdead_beef, 8'h0f});
      chk("w_hs", 64'({m_w_valid, lsu_w_ready, m_ar_valid}), 64'b110);
      @(posedge clk);
      @(negedge clk);
      lsu_w_valid = 1'b0;
      m_w_ready = 1'b0;
      m_b_valid = 1'b1;
      m_b_resp = SLVERR;
      lsu_b_ready = 1'b1;
      #1;
      chk("b_route", 64'({lsu_b_valid, m_b_ready, lsu_b_resp, m_ar_valid}), 64'b11100);
      @(posedge clk);
      @(negedge clk);
      m_b_valid = 1'b0;
      lsu_b_ready = 1'b0;
      sb.push_back('{2'b01, 64'hE5});
      rd_txn();
      ifu_ar_valid = 1'b0;
      // stray R/B from the slave while IDLE
      @(negedge clk);
      m_r_valid = 1'b1;
      m_b_valid = 1'b1;
      #1;
      chk("idle_stray", 64'({m_r_ready, ifu_r_valid, lsu_r_valid, m_b_ready, lsu_b_valid}), 64'd0);
      @(posedge clk);
      @(negedge clk);
      m_r_valid = 1'b0;
      m_b_valid = 1'b0;
      #1;
      chk("idle_stray_state", 64'(dut.state), 64'(S_IDLE));
      // reset during LSU_W
      lsu_aw_valid = 1'b1;
      m_aw_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lsu_aw_valid = 1'b0;
      m_aw_ready = 1'b0;
      lsu_w_valid = 1'b1;
      #1;
      chk("in_lsu_w", 64'(dut.state), 64'(S_LSU_W));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_mid_outputs", 64'(all_hs()), 64'd0);
      chk("rst_mid_state", 64'(dut.state), 64'(S_IDLE));
      rst = 1'b0;
      lsu_w_valid = 1'b0;
      ifu_ar_valid = 1'b1;
      lsu_ar_valid = 1'b1;
      sb.push_back('{2'b01, 64'hF6});
      sb.push_back('{2'b10, 64'h77});
      rd_txn();
      rd_txn();
      ifu_ar_valid = 1'b0;
      lsu_ar_valid = 1'b0;
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
